// File: rtl/joypad_port_if.sv
// ---------------------------------------------------------------------------
// joypad_port_if
//
// CPU-side bus bundle for the joypad port ($4016/$4017).
//
// Signals:
//   cpu_en   - CPU cycle enable. Bus accesses only count while this is high.
//   bus_addr - 16-bit CPU address.
//   bus_din  - 8-bit CPU write data.
//   bus_wr   - CPU R/W_n. 1 = read, 0 = write.
//   bus_out  - 8-bit read data from the port to the databus mux.
//   bus_sel  - High while a read of $4016 or $4017 is on the bus.
//
// Modports:
//   master - CPU / bus side. Drives address, data, enable and direction.
//   slave  - joypad_port side. Returns read data and the select flag.
// ---------------------------------------------------------------------------
interface joypad_port_if;
    logic        cpu_en;
    logic [15:0] bus_addr;
    logic [7:0]  bus_din;
    logic        bus_wr;
    logic [7:0]  bus_out;
    logic        bus_sel;

    modport master (
        output cpu_en,
        output bus_addr,
        output bus_din,
        output bus_wr,
        input  bus_out,
        input  bus_sel
    );

    modport slave (
        input  cpu_en,
        input  bus_addr,
        input  bus_din,
        input  bus_wr,
        output bus_out,
        output bus_sel
    );
endinterface

// File: rtl/joypad_port.sv
// ---------------------------------------------------------------------------
// joypad_port
//
// NES-style controller port. It polls a serial pad about 60 times a second
// and keeps the last captured button state. The CPU reads that state back
// one bit at a time through the usual $4016 strobe/shift protocol.
//
// Parameters:
//   POLL_DIV - cpu_clk cycles between the starts of two pad polls.
//   HALF_BIT - cpu_clk cycles in each half-period of pad_clk.
//
// Ports:
//   cpu_clk   - The only clock. All state changes on its rising edge.
//   reset_n   - Asynchronous, active-low reset.
//   bus       - CPU bus bundle, slave side (see joypad_port_if).
//   pad_latch - Latch pin to the controller.
//   pad_clk   - Clock pin to the controller.
//   pad_data  - Serial data from the controller. Active-low, pulled up.
//   buttons   - Last captured state, 1 = pressed.
//               bit0..7 = A, B, Select, Start, Up, Down, Left, Right.
//   sw        - Present only when JOYPAD_SW_OVERRIDE_EN is defined. Any bit
//               set here is ORed into buttons when a poll completes.
//
// Build option:
//   JOYPAD_SW_OVERRIDE_EN - Adds the sw override input. If it is not
//                           defined, buttons come from the pad alone.
// ---------------------------------------------------------------------------
module joypad_port #(
    parameter int POLL_DIV = 29830,
    parameter int HALF_BIT = 6
) (
    input  logic               cpu_clk,
    input  logic               reset_n,
    joypad_port_if.slave       bus,
    output logic               pad_latch,
    output logic               pad_clk,
    input  logic               pad_data,
    output logic [7:0]         buttons
`ifdef JOYPAD_SW_OVERRIDE_EN
    ,
    input  logic [7:0]         sw
`endif
);

    localparam int DIV_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam int TMR_W = $clog2(2 * HALF_BIT) + 1;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(POLL_DIV - 1);
    localparam logic [TMR_W-1:0] LATCH_LAST = TMR_W'(2 * HALF_BIT - 1);
    localparam logic [TMR_W-1:0] HALF_LAST  = TMR_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        BIT_LO,
        BIT_HI,
        DONE
    } poll_state_t;

    poll_state_t      state;
    logic [DIV_W-1:0] divider;
    logic [TMR_W-1:0] timer;
    logic [2:0]       bit_idx;
    logic [7:0]       capture;
    logic             sync_meta;
    logic             sync_data;
    logic             strobe;
    logic [7:0]       shift;

    logic             div_wrap;
    logic             addr_4016;
    logic             addr_4017;
    logic             strobe_wr;
    logic             shift_rd;
    logic             read_sel;
    logic [7:0]       read_data;
    logic             unused_din;

    // The strobe register only looks at bit 0 of the write data.
    assign unused_din = ^bus.bus_din[7:1];

    assign div_wrap  = (divider == DIV_LAST);
    assign addr_4016 = (bus.bus_addr == 16'h4016);
    assign addr_4017 = (bus.bus_addr == 16'h4017);
    assign strobe_wr = bus.cpu_en && !bus.bus_wr && addr_4016;
    assign shift_rd  = bus.cpu_en &&  bus.bus_wr && addr_4016;

    // The pad is on another board and runs on its own timing. Pass its data
    // through two flops before the FSM samples it.
    always_ff @(posedge cpu_clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= 1'b0;
            sync_data <= 1'b0;
        end else begin
            sync_meta <= pad_data;
            sync_data <= sync_meta;
        end
    end

    // The poll divider runs in every state. Because the poll does not stop
    // it, the time between two poll starts is exactly POLL_DIV cycles, no
    // matter how long the poll itself takes.
    always_ff @(posedge cpu_clk or negedge reset_n) begin
        if (!reset_n) begin
            divider <= '0;
        end else if (div_wrap) begin
            divider <= '0;
        end else begin
            divider <= divider + 1'b1;
        end
    end

    // Poll sequencer. It raises latch for two half-bits, then clocks out
    // eight bits. Each bit is sampled at the end of its low half, before the
    // rising pad_clk edge tells the pad to shift. pad_latch and pad_clk are
    // registered here so the pins never glitch. buttons changes only in DONE,
    // so an aborted poll leaves it untouched.
    always_ff @(posedge cpu_clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            timer     <= '0;
            bit_idx   <= '0;
            capture   <= '0;
            pad_latch <= 1'b0;
            pad_clk   <= 1'b0;
            buttons   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    pad_latch <= 1'b0;
                    pad_clk   <= 1'b0;
                    if (div_wrap) begin
                        state     <= LATCH;
                        pad_latch <= 1'b1;
                        timer     <= '0;
                    end
                end

                LATCH: begin
                    if (timer == LATCH_LAST) begin
                        state     <= BIT_LO;
                        pad_latch <= 1'b0;
                        timer     <= '0;
                        bit_idx   <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                BIT_LO: begin
                    if (timer == HALF_LAST) begin
                        capture[bit_idx] <= ~sync_data;
                        state            <= BIT_HI;
                        pad_clk          <= 1'b1;
                        timer            <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                BIT_HI: begin
                    if (timer == HALF_LAST) begin
                        pad_clk <= 1'b0;
                        timer   <= '0;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            state <= DONE;
                        end else begin
                            state <= BIT_LO;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                DONE: begin
`ifdef JOYPAD_SW_OVERRIDE_EN
                    buttons <= capture | sw;
`else
                    buttons <= capture;
`endif
                    state   <= IDLE;
                end

                default: begin
                    state     <= IDLE;
                    pad_latch <= 1'b0;
                    pad_clk   <= 1'b0;
                end
            endcase
        end
    end

    // CPU-facing strobe and shift register. While strobe is high, the shift
    // register keeps tracking buttons. Once strobe drops, each enabled $4016
    // read moves the next button into bit 0 and shifts a 1 in at the top, so
    // reads past the eighth return 1. A finished poll never touches shift
    // directly; only strobe reloads it. A strobe write of 1 reloads shift in
    // the same cycle, so it takes priority over a read shift.
    always_ff @(posedge cpu_clk or negedge reset_n) begin
        if (!reset_n) begin
            strobe <= 1'b0;
            shift  <= '0;
        end else begin
            if (strobe_wr && bus.bus_din[0]) begin
                shift <= buttons;
            end else if (strobe) begin
                shift <= buttons;
            end else if (shift_rd) begin
                shift <= {1'b1, shift[7:1]};
            end

            if (strobe_wr) begin
                strobe <= bus.bus_din[0];
            end
        end
    end

    // Read mux. Bit 6 is the open-bus value the CPU normally sees at these
    // addresses. While strobe is held high, a $4016 read shows the live A
    // button rather than the one-cycle-old copy in shift.
    always_comb begin
        read_sel  = (addr_4016 || addr_4017) && bus.bus_wr;
        read_data = 8'h00;
        if (read_sel) begin
            if (addr_4017) begin
                read_data = 8'h40;
            end else begin
                read_data = {7'b0100000, (strobe ? buttons[0] : shift[0])};
            end
        end
    end

    assign bus.bus_sel = read_sel;
    assign bus.bus_out = read_data;

endmodule

// File: tb/tb_joypad_port.sv
// ---------------------------------------------------------------------------
// tb_joypad_port
//
// Bench for joypad_port. It contains:
//   - a behavioural pad: latch loads the pattern, and each pad_clk rise
//     shifts out the next bit, active-low;
//   - a monitor that measures the latch width and counts pad_clk pulses;
//   - a reference model of the CPU protocol, kept as a queue of pending
//     bits. Strobe reloads the queue; reads pop from it; an empty queue
//     reads as 1.
// Stimulus uses random pad patterns and random bus cycles, plus fixed
// sequences for the known cases.
// ---------------------------------------------------------------------------
module tb_joypad_port;

    localparam int POLL_DIV = 300;
    localparam int HALF_BIT = 6;

    logic       cpu_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       pad_latch;
    logic       pad_clk;
    logic       pad_data;
    logic [7:0] buttons;
    logic [7:0] sw_val = 8'h00;

    joypad_port_if bus ();

    joypad_port #(
        .POLL_DIV (POLL_DIV),
        .HALF_BIT (HALF_BIT)
    ) dut (
        .cpu_clk   (cpu_clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .pad_latch (pad_latch),
        .pad_clk   (pad_clk),
        .pad_data  (pad_data),
        .buttons   (buttons)
`ifdef JOYPAD_SW_OVERRIDE_EN
        ,
        .sw        (sw_val)
`endif
    );

    // 10-unit clock period.
    always #5 cpu_clk = ~cpu_clk;

    logic [7:0] pad_pattern = 8'h00;
    logic [7:0] pad_shreg   = 8'hFF;
    logic       prev_latch  = 1'b0;
    logic       prev_clk    = 1'b0;
    int         latch_len   = 0;
    int         pulse_cnt   = 0;
    int         latch_rises = 0;

    assign pad_data = pad_shreg[0];

    // Pad model and pin monitor. Both run on the falling edge, away from the
    // DUT's active edge. While latch is high the pad presents button A; each
    // pad_clk rise moves to the next button. Released or missing bits read
    // high because of the pull-up.
    always @(negedge cpu_clk) begin
        if (pad_latch) begin
            pad_shreg <= ~pad_pattern;
        end else if (pad_clk && !prev_clk) begin
            pad_shreg <= {1'b1, pad_shreg[7:1]};
        end
        if (pad_latch && !prev_latch) begin
            latch_rises <= latch_rises + 1;
            latch_len   <= 1;
            pulse_cnt   <= 0;
        end else begin
            if (pad_latch) latch_len <= latch_len + 1;
            if (pad_clk && !prev_clk) pulse_cnt <= pulse_cnt + 1;
        end
        prev_latch <= pad_latch;
        prev_clk   <= pad_clk;
    end

    int         total = 0;
    int         bad   = 0;
    logic       model_strobe;
    bit         model_q[$];
    logic [7:0] exp_buttons;

    // Count one comparison and report it if it fails.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model state after reset: strobe is low and all eight shift bits are 0.
    task automatic modelReset();
        model_strobe = 1'b0;
        model_q.delete();
        for (int i = 0; i < 8; i++) model_q.push_back(1'b0);
    endtask

    task automatic modelLoad();
        model_q.delete();
        for (int i = 0; i < 8; i++) model_q.push_back(exp_buttons[i]);
    endtask

    // Drive one bus cycle. Check the combinational read outputs against the
    // model, then advance the model across the clock edge. The enable drops
    // right after the edge so that idle time between calls has no side
    // effects.
    task automatic applyStimulus(input logic en, input logic [15:0] addr, input logic [7:0] din,
                                 input logic wr, output logic [7:0] seen);
        logic       exp_sel;
        logic [7:0] exp_out;
        logic       rd_bit;
        logic       wr4016;
        logic       rd4016;
        @(negedge cpu_clk);
        bus.cpu_en   = en;
        bus.bus_addr = addr;
        bus.bus_din  = din;
        bus.bus_wr   = wr;
        #1;
        rd_bit  = model_strobe ? exp_buttons[0] : ((model_q.size() > 0) ? model_q[0] : 1'b1);
        exp_sel = wr && (addr == 16'h4016 || addr == 16'h4017);
        exp_out = !exp_sel ? 8'h00 : (addr == 16'h4017) ? 8'h40 : {7'b0100000, rd_bit};
        checkOutput("bus_sel", {31'd0, bus.bus_sel}, {31'd0, exp_sel});
        checkOutput("bus_out", {24'd0, bus.bus_out}, {24'd0, exp_out});
        seen = bus.bus_out;
        @(posedge cpu_clk);
        wr4016 = en && !wr && addr == 16'h4016;
        rd4016 = en &&  wr && addr == 16'h4016;
        if (model_strobe || (wr4016 && din[0])) modelLoad();
        else if (rd4016 && model_q.size() > 0) void'(model_q.pop_front());
        if (wr4016) model_strobe = din[0];
        #1;
        bus.cpu_en = 1'b0;
    endtask

    // Wait for the next poll to start, let it finish, then check its results.
    task automatic waitPoll();
        int r0 = latch_rises;
        logic seen = 1'b0;
        for (int i = 0; i < 2 * POLL_DIV; i++) begin
            @(negedge cpu_clk); #1;
            if (latch_rises != r0) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("poll_start", {31'd0, seen}, 32'd1);
        repeat (18 * HALF_BIT + 4) @(negedge cpu_clk);
        #1;
        checkOutput("buttons", {24'd0, buttons}, {24'd0, exp_buttons});
        checkOutput("latch_len", latch_len, 2 * HALF_BIT);
        checkOutput("clk_pulses", pulse_cnt, 8);
    endtask

    task automatic randomOps(input int n);
        logic [7:0]  dummy;
        logic [15:0] addr;
        int          s;
        for (int i = 0; i < n; i++) begin
            s = $urandom_range(0, 7);
            addr = (s < 4) ? 16'h4016 : (s < 6) ? 16'h4017 : (s == 6) ? 16'h4015 : 16'h5016;
            applyStimulus($urandom_range(0, 4) != 0, addr, 8'($urandom), $urandom_range(0, 3) != 0, dummy);
        end
    endtask

    // Watchdog: never let the run hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [7:0] seen;
    logic [7:0] seq36 [10] = '{8'h41, 8'h40, 8'h40, 8'h41, 8'h40, 8'h40, 8'h40, 8'h40, 8'h41, 8'h41};

    initial begin
        int n;
        int r0;
        bus.cpu_en   = 1'b0;
        bus.bus_addr = 16'h0000;
        bus.bus_din  = 8'h00;
        bus.bus_wr   = 1'b1;
        modelReset();
        exp_buttons = 8'h00;

        repeat (3) @(negedge cpu_clk);
        #1;
        checkOutput("rst_buttons", {24'd0, buttons}, 32'd0);
        checkOutput("rst_latch", {31'd0, pad_latch}, 32'd0);
        checkOutput("rst_clk", {31'd0, pad_clk}, 32'd0);
        @(negedge cpu_clk);
        reset_n = 1'b1;
        applyStimulus(1'b0, 16'h4016, 8'h00, 1'b1, seen);

        for (int it = 0; it < 5; it++) begin
            case (it)
                0: pad_pattern = 8'h09;
                1: pad_pattern = 8'h01;
                2: pad_pattern = 8'h00;
                default: pad_pattern = 8'($urandom);
            endcase
            sw_val = 8'h00;
`ifdef JOYPAD_SW_OVERRIDE_EN
            if (it == 2) sw_val = 8'h80;
`endif
            exp_buttons = pad_pattern | sw_val;
            waitPoll();

            if (it == 0) begin
                applyStimulus(1'b1, 16'h4016, 8'h01, 1'b0, seen);
                applyStimulus(1'b1, 16'h4016, 8'h00, 1'b0, seen);
                for (int k = 0; k < 10; k++) begin
                    applyStimulus(1'b1, 16'h4016, 8'h00, 1'b1, seen);
                    checkOutput("seq_read", {24'd0, seen}, {24'd0, seq36[k]});
                end
                applyStimulus(1'b1, 16'h4017, 8'h00, 1'b1, seen);
                applyStimulus(1'b1, 16'h4015, 8'h00, 1'b1, seen);
            end else if (it == 1) begin
                applyStimulus(1'b1, 16'h4016, 8'h01, 1'b0, seen);
                for (int k = 0; k < 3; k++) applyStimulus(1'b1, 16'h4016, 8'h00, 1'b1, seen);
                applyStimulus(1'b1, 16'h4016, 8'h00, 1'b0, seen);
                for (int k = 0; k < 9; k++) applyStimulus(1'b1, 16'h4016, 8'h00, 1'b1, seen);
            end
            randomOps(40);
        end

        // Reset partway through a poll, during the high half of bit 4.
        pad_pattern = 8'($urandom) | 8'h01;
        sw_val      = 8'h00;
        exp_buttons = pad_pattern;
        waitPoll();
        r0 = latch_rises;
        n  = 0;
        for (int i = 0; i < 2 * POLL_DIV; i++) begin
            @(negedge cpu_clk); #1;
            if (latch_rises != r0 && pulse_cnt == 5) begin
                n = 1;
                break;
            end
        end
        checkOutput("reach_bit4", n, 1);
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_clk", {31'd0, pad_clk}, 32'd0);
        checkOutput("midrst_latch", {31'd0, pad_latch}, 32'd0);
        checkOutput("midrst_buttons", {24'd0, buttons}, 32'd0);
        modelReset();
        exp_buttons = 8'h00;
        @(negedge cpu_clk);
        reset_n = 1'b1;
        n = 0;
        for (int i = 0; i < 2 * POLL_DIV; i++) begin
            @(posedge cpu_clk); #1;
            n++;
            if (pad_latch) break;
        end
        checkOutput("latch_after_rst", n, POLL_DIV);
        checkOutput("buttons_held", {24'd0, buttons}, 32'd0);
        repeat (18 * HALF_BIT + 4) @(negedge cpu_clk);
        #1;
        exp_buttons = pad_pattern;
        checkOutput("buttons_after_rst", {24'd0, buttons}, {24'd0, exp_buttons});
        randomOps(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/joypad_port.md
JOYPAD_PORT -- requirements
Module: joypad_port

Interface
REQ-001 Parameter POLL_DIV, default 29830, cpu_clk cycles between pad poll starts (~60 Hz at 1.79 MHz).
REQ-002 Parameter HALF_BIT, default 6, cpu_clk cycles per half-period of pad_clk.
REQ-003 cpu_clk  in  1  CPU clock; the only clock; all state on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 cpu_en  in  1  CPU cycle enable; bus accesses count only when high.
REQ-006 bus_addr  in  16  CPU address (low 16 bits of the system bus).
REQ-007 bus_din  in  8  CPU write data.
REQ-008 bus_wr  in  1  CPU R/W_n; 1 = read, 0 = write.
REQ-009 bus_out  out  8  read data for the databus mux.
REQ-010 bus_sel  out  1  high when bus_addr is $4016 or $4017 and bus_wr = 1.
REQ-011 pad_latch  out  1  controller latch pin.
REQ-012 pad_clk  out  1  controller clock pin.
REQ-013 pad_data  in  1  controller serial data; active-low; pulled up off-chip.
REQ-014 buttons  out  8  last captured state, 1 = pressed; bit0..7 = A,B,Select,Start,Up,Down,Left,Right.

Function
REQ-015 pad_data passes through a 2-flop synchroniser; all samples use the synchronised value.
REQ-016 The poll FSM has states IDLE, LATCH, BIT_LO, BIT_HI and DONE.
REQ-017 IDLE: pad_latch = 0, pad_clk = 0; the divider counts to POLL_DIV-1, then moves to LATCH and wraps to 0.
REQ-018 LATCH: pad_latch = 1 for 2*HALF_BIT cycles, then BIT_LO with bit index 0.
REQ-019 BIT_LO: pad_clk = 0 for HALF_BIT cycles; on the last cycle, capture[index] <= ~sync_data.
REQ-020 BIT_HI: pad_clk = 1 for HALF_BIT cycles; then index increments; index 7 goes to DONE, others to BIT_LO.
REQ-021 DONE: one cycle; buttons <= capture, then IDLE; buttons changes only here.
REQ-022 The divider free-runs in every state, so poll period = POLL_DIV cycles exactly; requires POLL_DIV > 24*HALF_BIT + 1.
REQ-023 An enabled write to $4016 (cpu_en = 1, bus_wr = 0) sets strobe <= bus_din[0].
REQ-024 While strobe = 1, shift <= buttons every cycle.
REQ-025 A read of $4016 returns {7'b0100000, shift[0]} combinationally.
REQ-026 On each enabled $4016 read cycle with strobe = 0, shift <= {1'b1, shift[7:1]}; after 8 reads, reads return bit0 = 1.
REQ-027 A read of $4017 returns 8'h40 and has no side effect; bus_out = 8'h00 when bus_sel = 0.
REQ-028 Read with strobe = 1: returns buttons[0] and does not shift.
REQ-029 Write to $4016 with bus_din[0] = 1 in the same cycle as a read shift: the write wins (impossible on one bus, but defined).
REQ-030 A DONE update during a shift sequence does not alter shift; only strobe reloads it.
REQ-031 Writes to $4017 and cycles with cpu_en = 0 are ignored.

Reset
REQ-032 Asserting reset_n low asynchronously forces:
- FSM to IDLE; divider, index and capture to 0;
- pad_latch, pad_clk, buttons, strobe, shift and synchroniser to 0.
REQ-033 Reset mid-poll aborts the poll with no buttons update; the first poll starts POLL_DIV cycles after release.

Configuration
REQ-034 Macro JOYPAD_SW_OVERRIDE_EN behaviour:
- Defined: an input port sw (8 bits) exists, and DONE loads buttons <= capture | sw; sw is sampled only in DONE.
- Undefined: the sw port is absent and buttons <= capture.

Verification
REQ-035 Pad model drives A and Start pressed (pad bits 0,3 low) -> after DONE, buttons = 8'h09; pad_latch high for 12 cycles; 8 pad_clk pulses.
REQ-036 Write $4016 = 1, then 0, then 10 reads with buttons = 8'h09 -> bus_out sequence 41,40,40,41,40,40,40,40,41,41.
REQ-037 strobe = 1, three reads of $4016 with buttons = 8'h01 -> each returns 8'h41; shift unchanged.
REQ-038 Read of $4017 -> 8'h40, bus_sel = 1; read of $4015 -> bus_sel = 0, bus_out = 8'h00.
REQ-039 reset_n pulsed low during BIT_HI of bit 4 -> outputs 0 immediately; next pad_latch rise is POLL_DIV cycles after release.
REQ-040 With JOYPAD_SW_OVERRIDE_EN, sw = 8'h80 and pad idle -> buttons = 8'h80 after DONE; without the macro, buttons = 8'h00.
